sram_arbiter: RTL

Two-port arbiter feeding the single-ported SRAM controller. Port 0 serves the video framebuffer fetch, port 1 the Hack CPU memory path. Each cycle it grants at most one port and forwards that port's request combinationally onto the controller's request bus. It returns read data to the owning port one cycle later, matching the controller's 1-cycle read latency. A starvation counter bounds how long the CPU can wait behind continuous video traffic.

---
 rtl/sram_arbiter_if.sv | 52 +++++
 rtl/sram_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Request/response bus between the two SRAM requesters, the arbiter and the
// single-ported SRAM controller. The arbiter takes the slave view; the
// requesters and controller model together take the master view.
interface sram_arbiter_if #(
    parameter int AW = 18,
    parameter int DW = 16
);
    logic              p0_valid;
    logic              p0_we;
    logic [AW-1:0]     p0_addr;
    logic [DW-1:0]     p0_wdata;
    logic [DW/8-1:0]   p0_wstrb;
    logic              p0_ready;
    logic              p0_rvalid;

    logic              p1_valid;
    logic              p1_we;
    logic [AW-1:0]     p1_addr;
    logic [DW-1:0]     p1_wdata;
    logic [DW/8-1:0]   p1_wstrb;
    logic              p1_ready;
    logic              p1_rvalid;

    logic [DW-1:0]     p_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wstrb;
    logic [DW-1:0]     mem_rdata;

    modport slave (
        input  p0_valid, p0_we, p0_addr, p0_wdata, p0_wstrb,
        output p0_ready, p0_rvalid,
        input  p1_valid, p1_we, p1_addr, p1_wdata, p1_wstrb,
        output p1_ready, p1_rvalid,
        output p_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    modport master (
        output p0_valid, p0_we, p0_addr, p0_wdata, p0_wstrb,
        input  p0_ready, p0_rvalid,
        output p1_valid, p1_we, p1_addr, p1_wdata, p1_wstrb,
        input  p1_ready, p1_rvalid,
        input  p_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the single-ported SRAM controller.
// Port 0 (video fetch) has priority; port 1 (CPU) is forced through after
// STARVE_MAX consecutive stalled cycles. Requests are forwarded
// combinationally, read data returns one cycle after acceptance.
module sram_arbiter #(
    parameter int AW         = 18,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    sram_arbiter_if.slave  bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam int SW = DW / 8;
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic          grant_p0_s;
    logic          grant_p1_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic [SW-1:0] sel_wstrb_s;

    logic          rd_pend_q, rd_pend_d;
    logic          rd_port_q, rd_port_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    // Pick at most one port: forced CPU grant when starved, else video first.
    always_comb begin
        grant_p0_s = 1'b0;
        grant_p1_s = 1'b0;
        if (reset) begin
            grant_p0_s = 1'b0;
            grant_p1_s = 1'b0;
        end else if ((starve_cnt_q == CNT_MAX) && bus.p1_valid) begin
            grant_p1_s = 1'b1;
        end else if (bus.p0_valid) begin
            grant_p0_s = 1'b1;
        end else if (bus.p1_valid) begin
            grant_p1_s = 1'b1;
        end else begin
            grant_p0_s = 1'b0;
            grant_p1_s = 1'b0;
        end
    end

    // Route the granted port's request fields; port 0 fields when idle are harmless.
    always_comb begin
        if (grant_p1_s) begin
            sel_we_s    = bus.p1_we;
            sel_addr_s  = bus.p1_addr;
            sel_wdata_s = bus.p1_wdata;
            sel_wstrb_s = bus.p1_wstrb;
        end else begin
            sel_we_s    = bus.p0_we;
            sel_addr_s  = bus.p0_addr;
            sel_wdata_s = bus.p0_wdata;
            sel_wstrb_s = bus.p0_wstrb;
        end
    end

    // Drive the controller bus; its byte mask is active-low, reads enable both lanes.
    always_comb begin
        bus.p0_ready  = grant_p0_s;
        bus.p1_ready  = grant_p1_s;
        bus.mem_addr  = sel_addr_s;
        bus.mem_wdata = sel_wdata_s;
        if (grant_p0_s || grant_p1_s) begin
            bus.mem_read  = ~sel_we_s;
            bus.mem_write = sel_we_s;
            if (sel_we_s) begin
                bus.mem_wstrb = ~sel_wstrb_s;
            end else begin
                bus.mem_wstrb = {SW{1'b0}};
            end
        end else begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            bus.mem_wstrb = {SW{1'b0}};
        end
    end

    // Next-state for read tracking and the CPU starvation counter.
    always_comb begin
        rd_pend_d    = 1'b0;
        rd_port_d    = grant_p1_s;
        starve_cnt_d = {CW{1'b0}};
        if (reset) begin
            rd_pend_d    = 1'b0;
            starve_cnt_d = {CW{1'b0}};
        end else begin
            rd_pend_d = (grant_p0_s || grant_p1_s) && !sel_we_s;
            if (bus.p1_valid && !grant_p1_s) begin
                if (starve_cnt_q == CNT_MAX) begin
                    starve_cnt_d = starve_cnt_q;
                end else begin
                    starve_cnt_d = starve_cnt_q + CW'(1);
                end
            end else begin
                starve_cnt_d = {CW{1'b0}};
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q    <= 1'b0;
            rd_port_q    <= 1'b0;
            starve_cnt_q <= {CW{1'b0}};
        end else begin
            rd_pend_q    <= rd_pend_d;
            rd_port_q    <= rd_port_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Return read data to the owning port; a read in flight across reset is dropped.
    always_comb begin
        bus.p_rdata   = bus.mem_rdata;
        bus.p0_rvalid = rd_pend_q && !rd_port_q && !reset;
        bus.p1_rvalid = rd_pend_q &&  rd_port_q && !reset;
    end
endmodule
